adat_generator: RTL and testbench
=================================

ADAT_GENERATOR -- requirements
Module: adat_generator

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, frame rate in Hz.
REQ-003 SHALL have parameter SMUX2_MODE, default 0; 1 = S/MUX2 (96 kHz) flagging.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge; the only clock.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port audio_in  input  array [0:7] of 24  channel samples, ch0..ch7.
REQ-007 SHALL have port user_in  input  4  user bits U3..U0.
REQ-008 SHALL have port start  input  1  level enable; while high, frames are generated back-to-back.
REQ-009 SHALL have port adat_out  output  1  NRZI-encoded ADAT stream.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-011 SHALL send 256-bit frames.
- Frame bit order: 10 zeros (sync), 1, U3..U0, 1.
- Then, for ch0..ch7, six nibbles MSB-first (bits 23..20 first), each nibble followed by a separator 1.
- Total length: 11 + 5 + 240 = 256.
REQ-012 SHALL NRZI-encode the stream: adat_out toggles at the start of a bit period for bit 1 and holds for bit 0.
REQ-013 SHALL derive bit timing from a phase accumulator, with no integer-divider rounding drift.
- Each clk adds SAMPLE_RATE*256.
- A bit tick occurs when the accumulator reaches CLK_FREQ; CLK_FREQ is then subtracted and the remainder kept.
- Accumulator width SHALL hold CLK_FREQ + SAMPLE_RATE*256 without overflow.
REQ-014 Defaults SHALL give 8 or 9 clocks per bit; frame period 2083 or 2084 clocks, long-run mean 2083.33.
REQ-015 SHALL implement states IDLE and SEND.
- IDLE → SEND: start sampled high on a clk edge.
- On that transition, latch audio_in and user_in into frame registers and clear bit index and accumulator.
- Bit 0 begins on the following cycle.
REQ-016 In SEND, inputs changing mid-frame SHALL NOT affect the current frame; only latched values are transmitted.
REQ-017 After bit 255 completes, frame_done SHALL pulse high for exactly one cycle, then:
- start high → re-latch inputs and begin the next frame with no gap (accumulator remainder preserved);
- start low → go to IDLE.
REQ-018 start deasserted mid-frame SHALL NOT truncate the frame; the frame completes and frame_done pulses.
REQ-019 In IDLE, adat_out SHALL hold its last level, and frame_done SHALL be 0.
REQ-020 When SMUX2_MODE=1, transmitted user bits SHALL be user_in with bit 2 forced to 1; channel data SHALL be sent unchanged (physical ch0..ch7).
REQ-021 When SMUX2_MODE=0, user bits SHALL be sent exactly as user_in.
REQ-022 Within each frame, the only run of more than 5 consecutive 0 bits SHALL be the sync (guaranteed by the separators).

Reset
REQ-023 On rst_n low, asynchronously:
- adat_out=0, frame_done=0;
- state=IDLE;
- accumulator, bit index and frame registers cleared.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; no frame_done pulse.
REQ-025 After rst_n rises, no output activity SHALL occur until start is sampled high.

Verification
REQ-026 Idle check: after reset with start=0 for 10 us -> adat_out constant 0, frame_done never pulses.
REQ-027 Frame timing: defaults, start held high for 10 frames -> frame_done pulse intervals each 2083 or 2084 clocks; 10-frame total within ±1 clock of 20833.
REQ-028 Decode, defaults:
- Stimulus: user_in=4'hA; audio_in = 123456, 789ABC, DEF012, 345678, 9ABCDE, F01234, 567890, ABCDEF.
- Response: NRZI-decoding adat_out sampled at bit centers recovers this data exactly.
- Each frame begins with a period of 10 bit times (~81 clocks) without a transition.
REQ-029 S/MUX2:
- Stimulus: SMUX2_MODE=1, user_in=0000, audio_in = AA0000, AA1111, BB0000, BB1111, CC0000, CC1111, DD0000, DD1111.
- Response: decoded user bits = 0100; all eight channels recovered unchanged.
REQ-030 Control boundaries:
- start dropped at bit ~100 -> frame completes to bit 255, frame_done pulses once, then IDLE with adat_out held.
- rst_n pulsed low mid-frame -> adat_out=0 immediately, no frame_done.

Source files
------------

// File: rtl/adat_generator.sv
// ADAT optical-stream generator: builds 256-bit frames from eight 24-bit channels
// plus four user bits, times them with a fractional phase accumulator and NRZI-encodes the result.
module adat_generator #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SAMPLE_RATE = 48000,
    parameter int SMUX2_MODE  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] audio_in [0:7],
    input  logic [3:0]  user_in,
    input  logic        start,
    output logic        adat_out,
    output logic        frame_done
);

    localparam longint STEP_L  = longint'(SAMPLE_RATE) * 256;
    localparam longint LIMIT_L = longint'(CLK_FREQ);
    localparam int     ACC_W   = $clog2(LIMIT_L + STEP_L + 1);
    localparam logic [ACC_W-1:0] STEP  = ACC_W'(STEP_L);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(LIMIT_L);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         bit_idx_q, bit_idx_d;
    logic [255:0]       sr_q, sr_d;
    logic               adat_q, adat_d;
    logic               done_q, done_d;

    logic [3:0]         user_tx;
    logic [255:0]       frame_bits;
    logic [ACC_W-1:0]   acc_sum;
    logic               tick;

    // S/MUX2 streams flag themselves by forcing user bit 2.
    assign user_tx = (SMUX2_MODE != 0) ? (user_in | 4'b0100) : user_in;

    // frame_bits[k] is the k-th bit on the wire.
    assign frame_bits[9:0] = '0;
    assign frame_bits[10]  = 1'b1;
    assign frame_bits[15]  = 1'b1;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_user
            assign frame_bits[11+gi] = user_tx[3-gi];
        end
        for (gi = 0; gi < 48; gi++) begin : g_nibble
            localparam int BASE = 16 + gi * 5;
            for (gj = 0; gj < 4; gj++) begin : g_bit
                assign frame_bits[BASE+gj] = audio_in[gi/6][23-4*(gi%6)-gj];
            end
            assign frame_bits[BASE+4] = 1'b1;
        end
    endgenerate

    assign acc_sum = acc_q + STEP;
    assign tick    = (acc_sum >= LIMIT);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_idx_d = bit_idx_q;
        sr_d      = sr_q;
        adat_d    = adat_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEND;
                    sr_d      = frame_bits;
                    bit_idx_d = '0;
                    acc_d     = '0;
                end
            end
            SEND: begin
                if (tick) begin
                    acc_d = acc_sum - LIMIT;
                    if (bit_idx_q == 8'd255) begin
                        // Next frame (if any) starts with sync zeros, so no toggle here.
                        done_d = 1'b1;
                        if (start) begin
                            sr_d      = frame_bits;
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 8'd1;
                        sr_d      = {1'b0, sr_q[255:1]};
                        if (sr_q[1]) begin
                            adat_d = ~adat_q;
                        end
                    end
                end else begin
                    acc_d = acc_sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            bit_idx_q <= '0;
            sr_q      <= '0;
            adat_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_idx_q <= bit_idx_d;
            sr_q      <= sr_d;
            adat_q    <= adat_d;
            done_q    <= done_d;
        end
    end

    assign adat_out   = adat_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_adat_generator.sv
// Bench for adat_generator: records the NRZI line every cycle, decodes it at nominal
// bit centres and compares against frames assembled from the documented bit order.
module tb_adat_generator;

    localparam longint C     = 100_000_000;
    localparam longint I     = 48000 * 256;
    localparam int     LVL_N = 24000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] audio_in [0:7];
    logic [3:0]  user_in;
    logic        adat_out0, frame_done0, adat_out1, frame_done1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int e_cyc = 0;
    bit cap_en = 0;
    int done_cnt0 = 0, done_cnt1 = 0, tog0 = 0, tog1 = 0;
    logic last0 = 1'b0, last1 = 1'b0;
    logic lvl0 [0:LVL_N-1];
    logic lvl1 [0:LVL_N-1];
    logic [23:0] exp_audio [0:9][0:7];
    logic [3:0]  exp_user [0:9];
    int done_rel [0:9];

    adat_generator #(.CLK_FREQ(100_000_000), .SAMPLE_RATE(48000), .SMUX2_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .audio_in(audio_in), .user_in(user_in),
        .start(start), .adat_out(adat_out0), .frame_done(frame_done0));

    adat_generator #(.CLK_FREQ(100_000_000), .SAMPLE_RATE(48000), .SMUX2_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .audio_in(audio_in), .user_in(user_in),
        .start(start), .adat_out(adat_out1), .frame_done(frame_done1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle observer: line levels relative to the capture origin plus event counters.
    always begin
        int rel;
        @(posedge clk);
        cyc++;
        #1;
        if (frame_done0) done_cnt0++;
        if (frame_done1) done_cnt1++;
        if (adat_out0 !== last0) tog0++;
        if (adat_out1 !== last1) tog1++;
        last0 = adat_out0;
        last1 = adat_out1;
        rel = cyc - e_cyc;
        if (cap_en && rel >= 0 && rel < LVL_N) begin
            lvl0[rel] = adat_out0;
            lvl1[rel] = adat_out1;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int center(input int j);
        return int'(((2 * longint'(j) + 1) * C) / (2 * I));
    endfunction

    function automatic int bit_start(input int j);
        return int'((longint'(j) * C + I - 1) / I);
    endfunction

    function automatic logic [255:0] exp_frame(input int f, input bit smux);
        logic [255:0] v;
        logic [3:0]   u;
        int p;
        v = '0;
        p = 10;
        v[p] = 1'b1; p++;
        u = smux ? (exp_user[f] | 4'b0100) : exp_user[f];
        for (int b = 3; b >= 0; b--) begin v[p] = u[b]; p++; end
        v[p] = 1'b1; p++;
        for (int ch = 0; ch < 8; ch++) begin
            for (int n = 0; n < 6; n++) begin
                for (int b = 23 - 4 * n; b >= 20 - 4 * n; b--) begin
                    v[p] = exp_audio[f][ch][b]; p++;
                end
                v[p] = 1'b1; p++;
            end
        end
        return v;
    endfunction

    task automatic randomize_slot(input int s);
        for (int ch = 0; ch < 8; ch++) exp_audio[s][ch] = 24'($urandom);
        exp_user[s] = 4'($urandom);
    endtask

    task automatic drive_slot(input int s);
        for (int ch = 0; ch < 8; ch++) audio_in[ch] = exp_audio[s][ch];
        user_in = exp_user[s];
    endtask

    task automatic drive_junk();
        for (int ch = 0; ch < 8; ch++) audio_in[ch] = 24'($urandom);
        user_in = 4'($urandom);
    endtask

    // Raise start on a falling edge; the following rising edge becomes capture index 0.
    task automatic begin_capture(output logic p0, output logic p1);
        @(negedge clk);
        p0 = adat_out0;
        p1 = adat_out1;
        e_cyc = cyc + 1;
        cap_en = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int rel, output bit ok);
        ok = 1'b0;
        rel = -1;
        for (int n = 0; n < limit; n++) begin
            @(posedge clk);
            #1;
            if (frame_done0) begin
                ok = 1'b1;
                rel = cyc - e_cyc;
                break;
            end
        end
    endtask

    task automatic decode_check(input int nfr, input logic p0_in, input logic p1_in);
        logic p0, p1;
        logic [255:0] g0, g1;
        int idx, s, e, nchg;
        p0 = p0_in;
        p1 = p1_in;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < 256; k++) begin
                idx = center(256 * f + k);
                g0[k] = lvl0[idx] ^ p0;
                g1[k] = lvl1[idx] ^ p1;
                p0 = lvl0[idx];
                p1 = lvl1[idx];
            end
            check($sformatf("frame%0d_dut0", f), g0, exp_frame(f, 1'b0));
            check($sformatf("frame%0d_dut1_smux", f), g1, exp_frame(f, 1'b1));
            check($sformatf("frame%0d_user_smux", f), {g1[11], g1[12], g1[13], g1[14]},
                  exp_user[f] | 4'b0100);
            s = bit_start(256 * f);
            e = center(256 * f + 9);
            nchg = 0;
            for (int i = s + 1; i <= e; i++) if (lvl0[i] !== lvl0[i-1]) nchg++;
            check($sformatf("frame%0d_sync_quiet", f), nchg, 0);
        end
    endtask

    initial begin
        logic p0, p1;
        int r, d0, d1, t0, t1, iv;
        bit ok;

        rst_n = 1'b0;
        start = 1'b0;
        user_in = '0;
        for (int ch = 0; ch < 8; ch++) audio_in[ch] = '0;
        #2;
        check("reset_adat0", adat_out0, 0);
        check("reset_done0", frame_done0, 0);
        check("reset_adat1", adat_out1, 0);
        check("reset_done1", frame_done1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle for 10 us.
        d0 = done_cnt0; d1 = done_cnt1; t0 = tog0; t1 = tog1;
        repeat (1000) @(negedge clk);
        check("idle_done0", done_cnt0 - d0, 0);
        check("idle_done1", done_cnt1 - d1, 0);
        check("idle_toggles0", tog0 - t0, 0);
        check("idle_toggles1", tog1 - t1, 0);
        check("idle_level0", adat_out0, 0);

        // Ten back-to-back frames; inputs for frame f+2 are applied during frame f+1.
        exp_user[0] = 4'hA;
        exp_audio[0][0] = 24'h123456; exp_audio[0][1] = 24'h789ABC;
        exp_audio[0][2] = 24'hDEF012; exp_audio[0][3] = 24'h345678;
        exp_audio[0][4] = 24'h9ABCDE; exp_audio[0][5] = 24'hF01234;
        exp_audio[0][6] = 24'h567890; exp_audio[0][7] = 24'hABCDEF;
        exp_user[1] = 4'h0;
        exp_audio[1][0] = 24'hAA0000; exp_audio[1][1] = 24'hAA1111;
        exp_audio[1][2] = 24'hBB0000; exp_audio[1][3] = 24'hBB1111;
        exp_audio[1][4] = 24'hCC0000; exp_audio[1][5] = 24'hCC1111;
        exp_audio[1][6] = 24'hDD0000; exp_audio[1][7] = 24'hDD1111;
        for (int s = 2; s < 10; s++) randomize_slot(s);

        drive_slot(0);
        d0 = done_cnt0; d1 = done_cnt1;
        begin_capture(p0, p1);
        drive_slot(1);
        for (int f = 0; f < 10; f++) begin
            wait_done(3000, r, ok);
            check($sformatf("frame%0d_done_seen", f), ok, 1);
            done_rel[f] = r;
            if (f <= 7) drive_slot(f + 2);
            else if (f == 8) start = 1'b0;
            else drive_junk();
        end
        for (int f = 1; f < 10; f++) begin
            iv = done_rel[f] - done_rel[f-1];
            check($sformatf("interval%0d_is_%0d", f, iv), (iv == 2083 || iv == 2084), 1);
        end
        check($sformatf("ten_frame_total_%0d", done_rel[9]),
              (done_rel[9] >= 20832 && done_rel[9] <= 20834), 1);
        @(negedge clk);
        check("done_pulses0", done_cnt0 - d0, 10);
        check("done_pulses1", done_cnt1 - d1, 10);
        t0 = tog0; d0 = done_cnt0;
        repeat (300) @(negedge clk);
        check("idle_hold_toggles", tog0 - t0, 0);
        check("idle_hold_done", done_cnt0 - d0, 0);
        cap_en = 1'b0;
        decode_check(10, p0, p1);

        // start dropped around bit 100: the frame still finishes.
        randomize_slot(0);
        drive_slot(0);
        d0 = done_cnt0;
        begin_capture(p0, p1);
        drive_junk();
        repeat (810) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2000, r, ok);
        check("drop_done_seen", ok, 1);
        check($sformatf("drop_frame_len_%0d", r), (r >= 2083 && r <= 2084), 1);
        @(negedge clk);
        t0 = tog0;
        repeat (300) @(negedge clk);
        check("drop_hold_toggles", tog0 - t0, 0);
        check("drop_done_once", done_cnt0 - d0, 1);
        cap_en = 1'b0;
        decode_check(1, p0, p1);

        // Reset in the middle of a frame while the line is high.
        begin_capture(p0, p1);
        cap_en = 1'b0;
        repeat (200) @(posedge clk);
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #3;
            if (adat_out0 === 1'b1) begin ok = 1'b1; break; end
        end
        check("line_high_before_reset", ok, 1);
        d0 = done_cnt0;
        rst_n = 1'b0;
        #1;
        check("async_reset_adat0", adat_out0, 0);
        check("async_reset_adat1", adat_out1, 0);
        check("async_reset_done0", frame_done0, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t0 = tog0;
        repeat (2500) @(negedge clk);
        check("post_reset_done", done_cnt0 - d0, 0);
        check("post_reset_toggles", tog0 - t0, 0);
        check("post_reset_level", adat_out0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
